// File: rtl/rtc_pkg.sv
// Shared types, BCD constants and calendar helper functions for the RTC date stage.
// Imported by rtc_days_in_month and rtc_calendar.
package rtc_pkg;

  typedef enum logic [2:0] {
    WdSun = 3'd0,
    WdMon = 3'd1,
    WdTue = 3'd2,
    WdWed = 3'd3,
    WdThu = 3'd4,
    WdFri = 3'd5,
    WdSat = 3'd6
  } wday_e;

  typedef struct packed {
    logic [2:0] wday;
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] day;
  } date_t;

  typedef struct packed {
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] day;
  } alarm_date_t;

  localparam logic [4:0] BcdMonthJan = 5'h01;
  localparam logic [4:0] BcdMonthFeb = 5'h02;
  localparam logic [4:0] BcdMonthDec = 5'h12;
  localparam logic [7:0] BcdYearMin  = 8'h00;
  localparam logic [7:0] BcdYearMax  = 8'h99;
  localparam logic [5:0] BcdDay01    = 6'h01;
  localparam logic [5:0] BcdDay28    = 6'h28;
  localparam logic [5:0] BcdDay29    = 6'h29;
  localparam logic [5:0] BcdDay30    = 6'h30;
  localparam logic [5:0] BcdDay31    = 6'h31;

  // Leap test on a BCD year within 2000-2099: divisible by 4 using digits only.
  function automatic logic is_leap_bcd(input logic [7:0] year);
    logic       tens_odd;
    logic [3:0] units;
    tens_odd = year[4];
    units    = year[3:0];
    return tens_odd ? (units == 4'd2 || units == 4'd6)
                    : (units == 4'd0 || units == 4'd4 || units == 4'd8);
  endfunction

  // Unknown month codes fall back to 31 days.
  function automatic logic [5:0] month_len(input logic [4:0] month, input logic leap);
    logic [5:0] len;
    case (month)
      5'h04, 5'h06, 5'h09, 5'h11: len = BcdDay30;
      BcdMonthFeb:                len = leap ? BcdDay29 : BcdDay28;
      default:                    len = BcdDay31;
    endcase
    return len;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// Combinational last-day-of-month lookup for a BCD month/year pair.
module rtc_days_in_month
  import rtc_pkg::*;
#(
  parameter bit LEAP_EN = 1'b1
) (
  input  logic [4:0] month_i,
  input  logic [7:0] year_i,
  output logic [5:0] last_day_o
);

  logic leap;

  always_comb begin
    leap       = LEAP_EN && is_leap_bcd(year_i);
    last_day_o = month_len(month_i, leap);
  end

endmodule

// File: rtl/rtc_calendar.sv
// BCD calendar stage: advances day/month/year/weekday on the end-of-day pulse
// and raises a one-shot date alarm plus a century-wrap pulse.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter logic [2:0] RST_WDAY = 3'd6,
  parameter bit         LEAP_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        update_day_i,
  input  logic        date_update_i,
  input  logic [21:0] date_i,
  output logic [21:0] date_o,
  input  logic        alarm_update_i,
  input  logic        alarm_enable_i,
  input  logic [18:0] alarm_date_i,
  output logic [18:0] alarm_date_o,
  output logic        alarm_enable_o,
  output logic        event_o,
  output logic        century_o
);

  localparam date_t ResetDate = '{
    wday:  RST_WDAY,
    year:  BcdYearMin,
    month: BcdMonthJan,
    day:   BcdDay01
  };

  date_t       date_q, date_d, date_next_day;
  alarm_date_t alarm_q, alarm_d;
  logic        alarm_en_q, alarm_en_d;
  logic        match, match_q;
  logic        century_q, century_d;
  logic [5:0]  last_day;
  logic        month_end, year_end, century_wrap;

  rtc_days_in_month #(
    .LEAP_EN(LEAP_EN)
  ) u_days_in_month (
    .month_i   (date_q.month),
    .year_i    (date_q.year),
    .last_day_o(last_day)
  );

  // >= rather than == so out-of-range written values still roll forward.
  always_comb begin
    date_next_day      = date_q;
    month_end          = date_q.day >= last_day;
    year_end           = date_q.month >= BcdMonthDec;
    century_wrap       = 1'b0;
    date_next_day.wday = (date_q.wday == WdSat) ? 3'(WdSun) : date_q.wday + 3'd1;
    if (month_end) begin
      date_next_day.day = BcdDay01;
      if (year_end) begin
        date_next_day.month = BcdMonthJan;
        if (date_q.year == BcdYearMax) begin
          date_next_day.year = BcdYearMin;
          century_wrap       = 1'b1;
        end else begin
          date_next_day.year = bcd_inc(date_q.year);
        end
      end else begin
        date_next_day.month = 5'(bcd_inc({3'b000, date_q.month}));
      end
    end else begin
      date_next_day.day = 6'(bcd_inc({2'b00, date_q.day}));
    end
  end

  always_comb begin
    date_d    = date_q;
    century_d = 1'b0;
    if (date_update_i) begin
      date_d = date_i;
    end else if (update_day_i) begin
      date_d    = date_next_day;
      century_d = century_wrap;
    end
  end

  // Rising edge of the match makes the alarm fire once per matching day.
  always_comb begin
    match      = ({date_q.year, date_q.month, date_q.day} == alarm_q);
    event_o    = alarm_en_q & match & ~match_q;
    alarm_d    = alarm_q;
    alarm_en_d = alarm_en_q;
    if (alarm_update_i) begin
      alarm_d    = alarm_date_i;
      alarm_en_d = alarm_enable_i;
    end else if (event_o) begin
      alarm_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      date_q     <= ResetDate;
      alarm_q    <= '0;
      alarm_en_q <= 1'b0;
      match_q    <= 1'b0;
      century_q  <= 1'b0;
    end else begin
      date_q     <= date_d;
      alarm_q    <= alarm_d;
      alarm_en_q <= alarm_en_d;
      match_q    <= match;
      century_q  <= century_d;
    end
  end

  assign date_o         = date_q;
  assign alarm_date_o   = alarm_q;
  assign alarm_enable_o = alarm_en_q;
  assign century_o      = century_q;

  century_lands_on_jan1 : assert property (@(posedge clk_i) disable iff (!rstn_i)
    century_q |-> (date_q.year == BcdYearMin && date_q.month == BcdMonthJan &&
                   date_q.day == BcdDay01));

  event_disarms : assert property (@(posedge clk_i) disable iff (!rstn_i)
    (event_o && !alarm_update_i) |=> !alarm_en_q);

endmodule
